// File: rtl/morse_transmitter.sv
// Morse keyer: accepts one letter A-Z per handshake and
// keys it out as marks/spaces timed in UNIT_CYCLES units.
module morse_transmitter #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       char_valid,
  input  logic [4:0] char_code,
  output logic       char_ready,
  output logic       key,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE, MARK, SPACE, CHARGAP
  } state_t;

  localparam logic [9:0] U1 = 10'(UNIT_CYCLES);
  localparam logic [9:0] U3 = 10'(3 * UNIT_CYCLES);

  state_t     state, state_d;
  logic [9:0] cnt, cnt_d;
  logic [1:0] idx, idx_d;
  logic [1:0] last, last_d;
  logic [3:0] pat, pat_d;
  logic       key_d, err_d;

  logic       tbl_ok;
  logic [1:0] tbl_last;
  logic [3:0] tbl_pat;

  // Letter table: last element index and left-aligned
  // pattern (bit 3 is the first element, 1 = dash).
  always_comb begin
    {tbl_ok, tbl_last, tbl_pat} = 7'b0_00_0000;
    unique case (char_code)
      5'd0:  {tbl_ok, tbl_last, tbl_pat} = 7'b1_01_0100;
      5'd1:  {tbl_ok, tbl_last, tbl_pat} = 7'b1_11_1000;
      5'd2:  {tbl_ok, tbl_last, tbl_pat} = 7'b1_11_1010;
      5'd3:  {tbl_ok, tbl_last, tbl_pat} = 7'b1_10_1000;
      5'd4:  {tbl_ok, tbl_last, tbl_pat} = 7'b1_00_0000;
      5'd5:  {tbl_ok, tbl_last, tbl_pat} = 7'b1_11_0010;
      5'd6:  {tbl_ok, tbl_last, tbl_pat} = 7'b1_10_1100;
      5'd7:  {tbl_ok, tbl_last, tbl_pat} = 7'b1_11_0000;
      5'd8:  {tbl_ok, tbl_last, tbl_pat} = 7'b1_01_0000;
      5'd9:  {tbl_ok, tbl_last, tbl_pat} = 7'b1_11_0111;
      5'd10: {tbl_ok, tbl_last, tbl_pat} = 7'b1_10_1010;
      5'd11: {tbl_ok, tbl_last, tbl_pat} = 7'b1_11_0100;
      5'd12: {tbl_ok, tbl_last, tbl_pat} = 7'b1_01_1100;
      5'd13: {tbl_ok, tbl_last, tbl_pat} = 7'b1_01_1000;
      5'd14: {tbl_ok, tbl_last, tbl_pat} = 7'b1_10_1110;
      5'd15: {tbl_ok, tbl_last, tbl_pat} = 7'b1_11_0110;
      5'd16: {tbl_ok, tbl_last, tbl_pat} = 7'b1_11_1101;
      5'd17: {tbl_ok, tbl_last, tbl_pat} = 7'b1_10_0100;
      5'd18: {tbl_ok, tbl_last, tbl_pat} = 7'b1_10_0000;
      5'd19: {tbl_ok, tbl_last, tbl_pat} = 7'b1_00_1000;
      5'd20: {tbl_ok, tbl_last, tbl_pat} = 7'b1_10_0010;
      5'd21: {tbl_ok, tbl_last, tbl_pat} = 7'b1_11_0001;
      5'd22: {tbl_ok, tbl_last, tbl_pat} = 7'b1_10_0110;
      5'd23: {tbl_ok, tbl_last, tbl_pat} = 7'b1_11_1001;
      5'd24: {tbl_ok, tbl_last, tbl_pat} = 7'b1_11_1011;
      5'd25: {tbl_ok, tbl_last, tbl_pat} = 7'b1_11_1100;
      default: {tbl_ok, tbl_last, tbl_pat} = 7'b0_00_0000;
    endcase
  end

  // Next state: each state runs for cnt cycles, and the
  // counter is reloaded with the new duration on every change.
  always_comb begin
    state_d = state;
    cnt_d   = cnt - 10'd1;
    idx_d   = idx;
    last_d  = last;
    pat_d   = pat;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = cnt;
        if (char_valid) begin
          idx_d  = 2'd0;
          last_d = tbl_last;
          pat_d  = tbl_pat;
          if (tbl_ok) begin
            state_d = MARK;
            cnt_d   = tbl_pat[3] ? U3 : U1;
          end else begin
            state_d = CHARGAP;
            cnt_d   = U3;
            err_d   = 1'b1;
          end
        end
      end
      MARK: begin
        if (cnt == 10'd1) begin
          if (idx == last) begin
            state_d = CHARGAP;
            cnt_d   = U3;
          end else begin
            state_d = SPACE;
            cnt_d   = U1;
            idx_d   = idx + 2'd1;
          end
        end
      end
      SPACE: begin
        if (cnt == 10'd1) begin
          state_d = MARK;
          cnt_d   = pat[~idx] ? U3 : U1;
        end
      end
      CHARGAP: begin
        if (cnt == 10'd1) begin
          state_d = IDLE;
          cnt_d   = 10'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 10'd0;
      end
    endcase
    key_d = (state_d == MARK);
  end

  // State, timing and registered key/err outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 10'd0;
      idx   <= 2'd0;
      last  <= 2'd0;
      pat   <= 4'd0;
      key   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      last  <= last_d;
      pat   <= pat_d;
      key   <= key_d;
      err   <= err_d;
    end
  end

  assign char_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign done       = (state == CHARGAP) && (cnt == 10'd1);

endmodule

// File: tb/tb_morse_transmitter.sv
// Directed bench for morse_transmitter at UNIT_CYCLES = 2.
// Waveforms are captured as bit strings, first sample at MSB.
module tb_morse_transmitter;

  logic       clk;
  logic       rst_n;
  logic       char_valid;
  logic [4:0] char_code;
  logic       char_ready;
  logic       key;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  logic [31:0] kv, dv, bv, rv, ev;

  morse_transmitter #(.UNIT_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_ready (char_ready),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample n negedges, the first being the current one.
  task automatic capture(input int n, input int drop_at,
                         input bit toggle);
    kv = '0; dv = '0; bv = '0; rv = '0; ev = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (i == drop_at) char_valid = 1'b0;
      kv = {kv[30:0], key};
      dv = {dv[30:0], done};
      bv = {bv[30:0], busy};
      rv = {rv[30:0], char_ready};
      ev = {ev[30:0], err};
      if (toggle) char_code = 5'(i * 7 + 3);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    char_valid = 1'b0;
    char_code = 5'd0;
    repeat (2) @(negedge clk);
    total++;
    if ({key, busy, done, err, char_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_outs got=%b want=00001",
               {key, busy, done, err, char_ready});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (char_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", char_ready);
    end
  endtask

  task automatic test_e;
    char_valid = 1'b1;
    char_code = 5'd4;
    @(negedge clk);
    capture(10, 0, 1'b0);
    total++;
    if (kv !== 32'(10'b1100000000)) begin
      bad++;
      $display("FAIL e_key got=%b want=1100000000", kv[9:0]);
    end
    total++;
    if (dv !== 32'(10'b0000000100)) begin
      bad++;
      $display("FAIL e_done got=%b want=0000000100", dv[9:0]);
    end
    total++;
    if (bv !== 32'(10'b1111111100)) begin
      bad++;
      $display("FAIL e_busy got=%b want=1111111100", bv[9:0]);
    end
    total++;
    if (rv !== 32'(10'b0000000011)) begin
      bad++;
      $display("FAIL e_ready got=%b want=0000000011", rv[9:0]);
    end
    total++;
    if (ev !== 32'd0) begin
      bad++;
      $display("FAIL e_err got=%b want=0", ev[9:0]);
    end
  endtask

  task automatic test_a;
    char_valid = 1'b1;
    char_code = 5'd0;
    @(negedge clk);
    capture(18, 0, 1'b0);
    total++;
    if (kv !== 32'(18'b110011111100000000)) begin
      bad++;
      $display("FAIL a_key got=%b want=110011111100000000",
               kv[17:0]);
    end
    total++;
    if (dv !== 32'(18'b000000000000000100)) begin
      bad++;
      $display("FAIL a_done got=%b want=000000000000000100",
               dv[17:0]);
    end
    total++;
    if (bv !== 32'(18'b111111111111111100)) begin
      bad++;
      $display("FAIL a_busy got=%b want=111111111111111100",
               bv[17:0]);
    end
  endtask

  task automatic test_back_to_back;
    char_valid = 1'b1;
    char_code = 5'd19;
    @(negedge clk);
    char_code = 5'd4;
    capture(22, 13, 1'b0);
    total++;
    if (kv !== 32'(22'b111111_0000000_11_0000000)) begin
      bad++;
      $display("FAIL b2b_key got=%b want=%b", kv[21:0],
               22'b111111_0000000_11_0000000);
    end
    total++;
    if (rv !== 32'(22'b000000_000000_1_00000000_1)) begin
      bad++;
      $display("FAIL b2b_ready got=%b want=%b", rv[21:0],
               22'b000000_000000_1_00000000_1);
    end
    total++;
    if (dv !== 32'(22'b00000000000_1_00000000_1_0)) begin
      bad++;
      $display("FAIL b2b_done got=%b want=%b", dv[21:0],
               22'b00000000000_1_00000000_1_0);
    end
  endtask

  task automatic test_invalid;
    char_valid = 1'b1;
    char_code = 5'd27;
    @(negedge clk);
    capture(8, 0, 1'b0);
    total++;
    if (ev !== 32'(8'b10000000)) begin
      bad++;
      $display("FAIL inv_err got=%b want=10000000", ev[7:0]);
    end
    total++;
    if (kv !== 32'd0) begin
      bad++;
      $display("FAIL inv_key got=%b want=00000000", kv[7:0]);
    end
    total++;
    if (dv !== 32'(8'b00000100)) begin
      bad++;
      $display("FAIL inv_done got=%b want=00000100", dv[7:0]);
    end
    total++;
    if (bv !== 32'(8'b11111100)) begin
      bad++;
      $display("FAIL inv_busy got=%b want=11111100", bv[7:0]);
    end
  endtask

  task automatic test_reset_mid;
    char_valid = 1'b1;
    char_code = 5'd16;
    @(negedge clk);
    capture(3, 0, 1'b0);
    total++;
    if (kv !== 32'(3'b111)) begin
      bad++;
      $display("FAIL q_dash got=%b want=111", kv[2:0]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({key, busy, done, char_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL q_rst got=%b want=0001",
               {key, busy, done, char_ready});
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL q_rst_done got=%b want=0", done);
    end
    rst_n = 1'b1;
    char_valid = 1'b1;
    char_code = 5'd4;
    @(negedge clk);
    capture(10, 0, 1'b0);
    total++;
    if (kv !== 32'(10'b1100000000)) begin
      bad++;
      $display("FAIL q_after_key got=%b want=1100000000",
               kv[9:0]);
    end
    total++;
    if (dv !== 32'(10'b0000000100)) begin
      bad++;
      $display("FAIL q_after_done got=%b want=0000000100",
               dv[9:0]);
    end
  endtask

  task automatic test_toggle;
    char_valid = 1'b1;
    char_code = 5'd7;
    @(negedge clk);
    capture(21, 10, 1'b1);
    total++;
    if (kv !== 32'(21'b11001100110011_0000000)) begin
      bad++;
      $display("FAIL tog_key got=%b want=%b", kv[20:0],
               21'b11001100110011_0000000);
    end
    total++;
    if (dv !== 32'(21'b0000000000000000000_1_0)) begin
      bad++;
      $display("FAIL tog_done got=%b want=%b", dv[20:0],
               21'b0000000000000000000_1_0);
    end
    total++;
    if (ev !== 32'd0) begin
      bad++;
      $display("FAIL tog_err got=%b want=0", ev[20:0]);
    end
  endtask

  initial begin
    test_reset;
    test_e;
    test_a;
    test_back_to_back;
    test_invalid;
    test_reset_mid;
    test_toggle;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_transmitter.md
MORSE_TRANSMITTER -- requirements
Module: morse_transmitter

Interface
REQ-001 Parameter UNIT_CYCLES, default 4, is the number of clk cycles in one Morse time unit; legal range is 1 to 255.
REQ-002 Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit, is the reset: asynchronous assertion, active-low.
REQ-004 Port char_valid, input, 1 bit, SHALL indicate that char_code holds a character to send.
REQ-005 Port char_code, input, 5 bits, SHALL carry the letter: 0 = A through 25 = Z; 26 to 31 are invalid.
REQ-006 Port char_ready, output, 1 bit, SHALL be high when the block can accept a character.
REQ-007 Port key, output, 1 bit, SHALL be the registered keying signal: 1 = tone (mark), 0 = silence.
REQ-008 Port busy, output, 1 bit, SHALL be high whenever the state is not IDLE.
REQ-009 Port done, output, 1 bit, SHALL pulse high for exactly one cycle at the end of each character, including an invalid one.
REQ-010 Port err, output, 1 bit, SHALL pulse high for one cycle, the cycle after an invalid code is accepted.

Function
REQ-011 The block SHALL be a four-state FSM with states IDLE, MARK, SPACE and CHARGAP.
REQ-012 A handshake SHALL occur when char_valid and char_ready are both high at a rising edge; char_ready SHALL equal (state == IDLE).
REQ-013 On a handshake, the block SHALL latch char_code into an internal table lookup giving a length (1 to 4 elements) and a pattern (1 = dash, sent MSB-first).
REQ-014 The table SHALL be standard International Morse for A to Z (for example A = .-, E = ., T = -, Q = --.-).
REQ-015 For a valid code, the cycle after the handshake the state SHALL be MARK with key = 1 (one-cycle latency).
REQ-016 A MARK SHALL last UNIT_CYCLES cycles for a dot and 3*UNIT_CYCLES cycles for a dash.
REQ-017 After a MARK, if elements remain, the state SHALL be SPACE (key = 0) for UNIT_CYCLES cycles, then the next MARK.
REQ-018 After the last MARK, the state SHALL be CHARGAP (key = 0) for 3*UNIT_CYCLES cycles.
REQ-019 For an invalid code, the state SHALL go directly to CHARGAP; key SHALL stay 0; err SHALL pulse.
REQ-020 done SHALL be asserted in the final cycle of CHARGAP; the following cycle SHALL be IDLE with char_ready = 1.
REQ-021 A back-to-back character SHALL be accepted in the first IDLE cycle, and its MARK SHALL start one cycle later; the minimum silence between characters is therefore 3*UNIT_CYCLES + 1 cycles.
REQ-022 The duration counter SHALL be 10 bits wide, count down, and reload on every state change; it SHALL not wrap at UNIT_CYCLES = 255.
REQ-023 char_code and char_valid SHALL be ignored while char_ready = 0; no queueing.
REQ-024 The element index SHALL be 2 bits wide; a length-4 character SHALL not wrap to a fifth element.

Reset
REQ-025 While rst_n = 0: state = IDLE; key, busy, done and err = 0; char_ready = 1; counter and element index = 0.
REQ-026 Reset asserted during MARK, SPACE or CHARGAP SHALL force key = 0 immediately (asynchronously) and abandon the character with no done pulse.
REQ-027 On the first edge after rst_n rises, a handshake SHALL be accepted.

Verification
REQ-028 Send E (code 4) with UNIT_CYCLES = 2 -> key 1 for 2 cycles, then 0 for 6 cycles, with done in the 6th low cycle; busy is high for 8 cycles.
REQ-029 Send A (code 0) with UNIT_CYCLES = 2 -> key pattern 1,1,0,0,1,1,1,1,1,1 followed by 6 zeros, then done.
REQ-030 Send T then E back-to-back with char_valid held high -> a 6-cycle mark, then 7 low cycles, then a 2-cycle mark; char_ready is high for exactly 1 cycle between the two characters.
REQ-031 Send code 27 -> err pulses at cycle +1, key stays 0, done pulses after 3*UNIT_CYCLES cycles.
REQ-032 Assert rst_n low in the 3rd cycle of the dash in Q -> key drops to 0 the same cycle, no done pulse, char_ready = 1 after release.
REQ-033 Toggle char_code while busy -> the transmitted pattern is unchanged.
